// File: rtl/determinante_pkg.sv
// Shared types and constants for the sequential determinant block.
//   state_t     : controller states (IDLE, CALC, FIM)
//   op_t        : per-step opcode driven into determinante_mac
//   step_t      : decoded step (opcode plus operand selects)
//   step_decode : maps (mode, step index) to the operation for that CALC cycle
package determinante_pkg;

    typedef enum logic [1:0] {IDLE, CALC, FIM} state_t;

    localparam logic TAM_2X2 = 1'b0;
    localparam logic TAM_3X3 = 1'b1;

    localparam logic [3:0] N_2X2 = 4'd2;
    localparam logic [3:0] N_3X3 = 4'd9;

    // Element indices into the row-major matrix a..i.
    localparam logic [3:0] EL_A = 4'd0;
    localparam logic [3:0] EL_B = 4'd1;
    localparam logic [3:0] EL_C = 4'd2;
    localparam logic [3:0] EL_D = 4'd3;
    localparam logic [3:0] EL_E = 4'd4;
    localparam logic [3:0] EL_F = 4'd5;
    localparam logic [3:0] EL_G = 4'd6;
    localparam logic [3:0] EL_H = 4'd7;
    localparam logic [3:0] EL_I = 4'd8;

    typedef enum logic [2:0] {
        OP_NOP,
        OP_M_LOAD,
        OP_M_SUB,
        OP_ACC_LOAD,
        OP_ACC_ADD,
        OP_ACC_SUB
    } op_t;

    // use_m selects the minor register m as the second multiplier operand
    // instead of element y_sel.
    typedef struct packed {
        op_t        op;
        logic [3:0] x_sel;
        logic [3:0] y_sel;
        logic       use_m;
    } step_t;

    function automatic step_t mk_step(input op_t op, input logic [3:0] x_sel,
                                      input logic [3:0] y_sel, input logic use_m);
        step_t s;
        s.op    = op;
        s.x_sel = x_sel;
        s.y_sel = y_sel;
        s.use_m = use_m;
        return s;
    endfunction

    // 3x3 is a cofactor expansion along the first row: each 2x2 minor is built
    // in m over two cycles, then folded into acc by the matching row-0 element.
    function automatic step_t step_decode(input logic tamanho, input logic [3:0] step);
        step_t s;
        s = mk_step(OP_NOP, EL_A, EL_A, 1'b0);
        if (tamanho == TAM_2X2) begin
            case (step)
                4'd0:    s = mk_step(OP_ACC_LOAD, EL_A, EL_E, 1'b0);
                4'd1:    s = mk_step(OP_ACC_SUB,  EL_B, EL_D, 1'b0);
                default: s = mk_step(OP_NOP,      EL_A, EL_A, 1'b0);
            endcase
        end else begin
            case (step)
                4'd0:    s = mk_step(OP_M_LOAD,   EL_E, EL_I, 1'b0);
                4'd1:    s = mk_step(OP_M_SUB,    EL_F, EL_H, 1'b0);
                4'd2:    s = mk_step(OP_ACC_LOAD, EL_A, EL_A, 1'b1);
                4'd3:    s = mk_step(OP_M_LOAD,   EL_D, EL_I, 1'b0);
                4'd4:    s = mk_step(OP_M_SUB,    EL_F, EL_G, 1'b0);
                4'd5:    s = mk_step(OP_ACC_SUB,  EL_B, EL_A, 1'b1);
                4'd6:    s = mk_step(OP_M_LOAD,   EL_D, EL_H, 1'b0);
                4'd7:    s = mk_step(OP_M_SUB,    EL_E, EL_G, 1'b0);
                4'd8:    s = mk_step(OP_ACC_ADD,  EL_C, EL_A, 1'b1);
                default: s = mk_step(OP_NOP,      EL_A, EL_A, 1'b0);
            endcase
        end
        return s;
    endfunction

endpackage

// File: rtl/determinante_mac.sv
// Single signed multiplier with load/add/subtract into the accumulator or
// the minor register m.
//   clk, reset : clock and synchronous active-high reset (clears acc and m)
//   op         : operation for this cycle (OP_NOP holds both registers)
//   x          : first multiplier operand (matrix element)
//   y_elem     : second operand when use_m = 0 (matrix element)
//   use_m      : take the second operand from m
//   acc_next   : accumulator value after this cycle's operation
module determinante_mac
    import determinante_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 3 * DATA_W + 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  op_t                      op,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] y_elem,
    input  logic                     use_m,
    output logic signed [ACC_W-1:0]  acc_next
);

    localparam int M_W = 2 * DATA_W + 1;
    localparam int P_W = 3 * DATA_W + 1;

    logic signed [M_W-1:0]   m_q, m_d, y_op;
    logic signed [P_W-1:0]   x_ext, y_ext, prod;
    logic signed [ACC_W-1:0] acc_q, acc_d, prod_ext;

    always_comb begin
        y_op     = use_m ? m_q : {{(M_W - DATA_W){y_elem[DATA_W-1]}}, y_elem};
        x_ext    = {{(P_W - DATA_W){x[DATA_W-1]}}, x};
        y_ext    = {{(P_W - M_W){y_op[M_W-1]}}, y_op};
        prod     = x_ext * y_ext;
        prod_ext = {{(ACC_W - P_W){prod[P_W-1]}}, prod};
    end

    // m only ever takes element*element products, which fit in 2*DATA_W bits,
    // so the low M_W bits of prod are exact and the difference never wraps.
    always_comb begin
        m_d   = m_q;
        acc_d = acc_q;
        unique case (op)
            OP_M_LOAD:   m_d   = prod[M_W-1:0];
            OP_M_SUB:    m_d   = m_q - prod[M_W-1:0];
            OP_ACC_LOAD: acc_d = prod_ext;
            OP_ACC_ADD:  acc_d = acc_q + prod_ext;
            OP_ACC_SUB:  acc_d = acc_q - prod_ext;
            default:     ;
        endcase
    end

    assign acc_next = acc_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            m_q   <= '0;
            acc_q <= '0;
        end else begin
            m_q   <= m_d;
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/determinante_seq.sv
// Sequential 2x2 / 3x3 signed determinant using one shared multiplier.
//   clk, reset    : clock and synchronous active-high reset
//   start         : request a computation (accepted in IDLE or FIM)
//   tamanho       : 0 = 2x2, 1 = 3x3, latched with start
//   matriz        : row-major a..i, a in the MSBs, latched with start
//   det           : result truncated to DATA_W bits
//   det_completo  : full-precision result
//   overflow_flag : det_completo does not fit in DATA_W signed bits
//   busy          : computation in progress (state CALC)
//   done          : one-cycle pulse in FIM; results valid from here on
module determinante_seq
    import determinante_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 3 * DATA_W + 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     tamanho,
    input  logic [9*DATA_W-1:0]      matriz,
    output logic signed [DATA_W-1:0] det,
    output logic signed [ACC_W-1:0]  det_completo,
    output logic                     overflow_flag,
    output logic                     busy,
    output logic                     done
);

    if (ACC_W < 3 * DATA_W + 2) begin : g_acc_w_check
        $error("ACC_W must be at least 3*DATA_W+2");
    end

    state_t                state_q;
    logic [3:0]            step_q;
    logic                  tam_q;
    logic [9*DATA_W-1:0]   matriz_q;

    logic signed [DATA_W-1:0] elem [9];
    step_t                    cur;
    op_t                      mac_op;
    logic signed [ACC_W-1:0]  acc_next;
    logic                     last_step;
    logic                     ovf_next;

    always_comb begin
        for (int k = 0; k < 9; k++) begin
            elem[k] = matriz_q[(8 - k) * DATA_W +: DATA_W];
        end
    end

    always_comb begin
        cur       = step_decode(tam_q, step_q);
        mac_op    = (state_q == CALC) ? cur.op : OP_NOP;
        last_step = (step_q == ((tam_q == TAM_3X3) ? N_3X3 - 4'd1 : N_2X2 - 4'd1));
        // Out of range iff the upper bits are not a sign extension of bit DATA_W-1.
        ovf_next  = (acc_next != {{(ACC_W - DATA_W){acc_next[DATA_W-1]}},
                                  acc_next[DATA_W-1:0]});
    end

    determinante_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .op       (mac_op),
        .x        (elem[cur.x_sel]),
        .y_elem   (elem[cur.y_sel]),
        .use_m    (cur.use_m),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            step_q        <= '0;
            tam_q         <= TAM_2X2;
            matriz_q      <= '0;
            det           <= '0;
            det_completo  <= '0;
            overflow_flag <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            unique case (state_q)
                CALC: begin
                    if (last_step) begin
                        state_q       <= FIM;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        det           <= acc_next[DATA_W-1:0];
                        det_completo  <= acc_next;
                        overflow_flag <= ovf_next;
                    end else begin
                        step_q <= step_q + 4'd1;
                    end
                end
                default: begin
                    // IDLE and FIM both accept start; results are left untouched.
                    if (start) begin
                        state_q  <= CALC;
                        step_q   <= '0;
                        tam_q    <= tamanho;
                        matriz_q <= matriz;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_determinante_seq.sv
module tb_determinante_seq;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              tamanho;
    logic [71:0]       matriz;
    logic signed [7:0] det;
    logic [25:0]       det_completo;
    logic              overflow_flag;
    logic              busy;
    logic              done;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        longint      full;
        logic [7:0]  low;
        logic        ovf;
        int          lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    determinante_seq dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .tamanho       (tamanho),
        .matriz        (matriz),
        .det           (det),
        .det_completo  (det_completo),
        .overflow_flag (overflow_flag),
        .busy          (busy),
        .done          (done)
    );

    function automatic logic [71:0] pack(input int a, input int b, input int c,
                                         input int d, input int e, input int f,
                                         input int g, input int h, input int i);
        return {8'(a), 8'(b), 8'(c), 8'(d), 8'(e), 8'(f), 8'(g), 8'(h), 8'(i)};
    endfunction

    // Closed-form reference (Sarrus / ad-bc).
    function automatic exp_t model(input logic tam, input logic [71:0] mz);
        exp_t   r;
        longint v [9];
        logic [7:0] byte_v;
        for (int k = 0; k < 9; k++) begin
            byte_v = mz[(8 - k) * 8 +: 8];
            v[k]   = longint'($signed(byte_v));
        end
        if (tam) begin
            r.full = v[0]*v[4]*v[8] + v[1]*v[5]*v[6] + v[2]*v[3]*v[7]
                   - v[2]*v[4]*v[6] - v[1]*v[3]*v[8] - v[0]*v[5]*v[7];
            r.lat  = 9;
        end else begin
            r.full = v[0]*v[4] - v[1]*v[3];
            r.lat  = 2;
        end
        r.low = r.full[7:0];
        r.ovf = (r.full < -128) || (r.full > 127);
        return r;
    endfunction

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic tam, input logic [71:0] mz);
        tamanho = tam;
        matriz  = mz;
        start   = 1'b1;
        sb.push_back(model(tam, mz));
    endtask

    // Counts edges after the start edge until done; capped so it always returns.
    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 30) begin
            step_clk();
            lat++;
            if (done) break;
        end
    endtask

    task automatic test_reset();
        exp_t dummy;
        reset = 1'b1;
        issue(1'b1, pack(6, 1, 1, 4, -2, 5, 2, 8, 7));
        dummy = sb.pop_back();
        repeat (3) step_clk();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (det !== 8'sd0) begin n_fail++; $display("FAIL reset_det: got %0d expected 0", det); end
        n_cmp++; if (det_completo !== 26'd0) begin n_fail++; $display("FAIL reset_detc: got %0d expected 0", det_completo); end
        n_cmp++; if (overflow_flag !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", overflow_flag); end
        start = 1'b0;
        reset = 1'b0;
        step_clk();
    endtask

    task automatic test_2x2();
        exp_t ex;
        int   lat;
        logic signed [7:0] held;
        issue(1'b0, pack(3, 8, 0, 4, 6, 0, 0, 0, 0));
        step_clk();
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL 2x2_busy: got %b expected 1", busy); end
        wait_done(lat);
        ex = sb.pop_front();
        n_cmp++; if (lat !== ex.lat) begin n_fail++; $display("FAIL 2x2_latency: got %0d expected %0d", lat, ex.lat); end
        n_cmp++; if (det !== ex.low) begin n_fail++; $display("FAIL 2x2_det: got %0d expected %0d", det, $signed(ex.low)); end
        n_cmp++; if (longint'($signed(det_completo)) !== ex.full) begin n_fail++; $display("FAIL 2x2_detc: got %0d expected %0d", $signed(det_completo), ex.full); end
        n_cmp++; if (overflow_flag !== ex.ovf) begin n_fail++; $display("FAIL 2x2_ovf: got %b expected %b", overflow_flag, ex.ovf); end
        held = det;
        step_clk();
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width: got %b expected 0", done); end
        n_cmp++; if (det !== held) begin n_fail++; $display("FAIL det_hold: got %0d expected %0d", det, held); end
    endtask

    task automatic test_3x3(input string name, input logic tam, input logic [71:0] mz);
        exp_t ex;
        int   lat;
        issue(tam, mz);
        step_clk();
        start = 1'b0;
        wait_done(lat);
        ex = sb.pop_front();
        n_cmp++; if (lat !== ex.lat) begin n_fail++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, ex.lat); end
        n_cmp++; if (det !== ex.low) begin n_fail++; $display("FAIL %s_det: got %0d expected %0d", name, det, $signed(ex.low)); end
        n_cmp++; if (longint'($signed(det_completo)) !== ex.full) begin n_fail++; $display("FAIL %s_detc: got %0d expected %0d", name, $signed(det_completo), ex.full); end
        n_cmp++; if (overflow_flag !== ex.ovf) begin n_fail++; $display("FAIL %s_ovf: got %b expected %b", name, overflow_flag, ex.ovf); end
        step_clk();
    endtask

    task automatic test_back_to_back();
        exp_t ex;
        int   lat;
        issue(1'b1, pack(1, 0, 0, 0, 1, 0, 0, 0, 1));
        step_clk();
        start = 1'b0;
        wait_done(lat);
        ex = sb.pop_front();
        n_cmp++; if (det !== ex.low) begin n_fail++; $display("FAIL b2b_first_det: got %0d expected %0d", det, $signed(ex.low)); end
        // Second start lands on the done cycle.
        issue(1'b0, pack(3, 8, 0, 4, 6, 0, 0, 0, 0));
        step_clk();
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_no_idle: got busy %b expected 1", busy); end
        n_cmp++; if (det !== ex.low) begin n_fail++; $display("FAIL b2b_prev_visible: got %0d expected %0d", det, $signed(ex.low)); end
        wait_done(lat);
        ex = sb.pop_front();
        n_cmp++; if (lat !== ex.lat) begin n_fail++; $display("FAIL b2b_latency: got %0d expected %0d", lat, ex.lat); end
        n_cmp++; if (det !== ex.low) begin n_fail++; $display("FAIL b2b_second_det: got %0d expected %0d", det, $signed(ex.low)); end
        step_clk();
    endtask

    task automatic test_reset_mid();
        exp_t dummy;
        int   n_done;
        issue(1'b1, pack(6, 1, 1, 4, -2, 5, 2, 8, 7));
        step_clk();
        start = 1'b0;
        repeat (4) step_clk();
        dummy = sb.pop_back();
        reset = 1'b1;
        step_clk();
        reset = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b expected 0", busy); end
        n_cmp++; if (det !== 8'sd0) begin n_fail++; $display("FAIL rmid_det: got %0d expected 0", det); end
        n_cmp++; if (det_completo !== 26'd0) begin n_fail++; $display("FAIL rmid_detc: got %0d expected 0", det_completo); end
        n_done = 0;
        repeat (12) begin
            step_clk();
            if (done) n_done++;
        end
        n_cmp++; if (n_done !== 0) begin n_fail++; $display("FAIL rmid_no_done: got %0d pulses expected 0", n_done); end
        test_3x3("rmid_after", 1'b1, pack(6, 1, 1, 4, -2, 5, 2, 8, 7));
    endtask

    task automatic test_ignore_calc();
        exp_t ex;
        int   lat;
        logic [95:0] junk;
        issue(1'b1, pack(2, -3, 5, 7, 1, -4, 0, 6, 9));
        step_clk();
        lat = 0;
        while (lat < 30) begin
            junk    = {$urandom(), $urandom(), $urandom()};
            matriz  = junk[71:0];
            tamanho = ~tamanho;
            start   = junk[72];
            step_clk();
            lat++;
            if (done) break;
        end
        start = 1'b0;
        ex = sb.pop_front();
        n_cmp++; if (lat !== ex.lat) begin n_fail++; $display("FAIL ign_latency: got %0d expected %0d", lat, ex.lat); end
        n_cmp++; if (longint'($signed(det_completo)) !== ex.full) begin n_fail++; $display("FAIL ign_detc: got %0d expected %0d", $signed(det_completo), ex.full); end
        step_clk();
    endtask

    task automatic test_random();
        exp_t ex;
        int   lat;
        logic [95:0] junk;
        for (int t = 0; t < 12; t++) begin
            junk = {$urandom(), $urandom(), $urandom()};
            issue(t[0], junk[71:0]);
            step_clk();
            start = 1'b0;
            wait_done(lat);
            ex = sb.pop_front();
            n_cmp++; if (lat !== ex.lat) begin n_fail++; $display("FAIL rand%0d_latency: got %0d expected %0d", t, lat, ex.lat); end
            n_cmp++; if (longint'($signed(det_completo)) !== ex.full || det !== ex.low || overflow_flag !== ex.ovf) begin
                n_fail++;
                $display("FAIL rand%0d_result: got %0d/%0d/%b expected %0d/%0d/%b", t,
                         $signed(det_completo), det, overflow_flag, ex.full, $signed(ex.low), ex.ovf);
            end
            step_clk();
        end
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        tamanho = 1'b0;
        matriz  = '0;
        test_reset();
        test_2x2();
        test_3x3("3x3", 1'b1, pack(6, 1, 1, 4, -2, 5, 2, 8, 7));
        test_3x3("ovf2x2", 1'b0, pack(-128, 127, 0, 127, -128, 0, 0, 0, 0));
        test_3x3("3x3_extreme", 1'b1, pack(-128, 127, -128, 127, -128, 127, -128, 127, -128));
        test_back_to_back();
        test_reset_mid();
        test_ignore_calc();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/determinante_seq.md
DETERMINANTE_SEQ -- requirements
Module: determinante_seq

Interface
REQ-001 Parameter DATA_W, default 8: signed width of each matrix element and of det.
REQ-002 Parameter ACC_W, default 3*DATA_W+2: internal accumulator and det_completo width; it SHALL NOT be set below 3*DATA_W+2.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a computation; sampled only when the block is ready.
REQ-006 tamanho  input  1  mode select: 0 = 2x2, 1 = 3x3; sampled with start.
REQ-007 matriz  input  9*DATA_W  row-major a..i, with a in the MSBs; 2x2 mode uses a, b, d, e only.
REQ-008 det  output  DATA_W  signed result, truncated to the low DATA_W bits.
REQ-009 det_completo  output  ACC_W  signed full-precision result.
REQ-010 overflow_flag  output  1  high when det_completo lies outside [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-011 busy  output  1  high while a computation is in progress.
REQ-012 done  output  1  one-cycle pulse; results are valid from this cycle onward.

Function
REQ-013 FSM states: IDLE, CALC, FIM.
- IDLE -> CALC on start.
- CALC -> FIM after the last step.
- FIM -> CALC on start, otherwise FIM -> IDLE.
REQ-014 start SHALL be accepted in IDLE or FIM and ignored in CALC; on acceptance, matriz and tamanho are latched and the step counter is cleared.
REQ-015 One signed multiplier SHALL be used, one product per CALC cycle.
REQ-016 Step order, 2x2 (N=2): acc=a*e; acc-=b*d.
REQ-017 Step order, 3x3 (N=9), with m a 2*DATA_W+1 bit register:
- m=e*i; m-=f*h; acc=a*m
- m=d*i; m-=f*g; acc-=b*m
- m=d*h; m-=e*g; acc+=c*m
REQ-018 All arithmetic SHALL be sign-extended to full width; intermediates never wrap.
REQ-019 Latency: start is sampled at edge t0, CALC steps execute at edges t0+1..t0+N, and FIM is entered at edge t0+N, so done=1 during cycle t0+N to t0+N+1. This gives 2 cycles (2x2) or 9 cycles (3x3) from the start edge to done.
REQ-020 det, det_completo and overflow_flag SHALL update only at the edge entering FIM and hold until the next FIM entry.
REQ-021 busy = (state==CALC); done = (state==FIM).
REQ-022 Changes on matriz or tamanho during CALC SHALL NOT affect the result in progress.
REQ-023 Back-to-back operation: start while done=1 begins a new computation with no idle cycle, and the previous results stay visible until the new FIM.

Reset
REQ-024 reset=1 at any edge SHALL force IDLE, clear the step counter, acc and m, and drive det, det_completo, overflow_flag, busy and done to 0.
REQ-025 reset has priority over start; a computation interrupted by reset SHALL produce no done pulse.

Structure
REQ-026 Package determinante_pkg SHALL hold:
- the state enum (IDLE, CALC, FIM)
- mode constants TAM_2X2=0 and TAM_3X3=1
- step-count constants N_2X2=2 and N_3X3=9
REQ-027 Sub-module determinante_mac SHALL hold the single multiplier plus the add/subtract/load into acc or m, controlled by a per-step opcode from the FSM.

Verification (DATA_W=8)
REQ-028 2x2 [3,8;4,6] -> done 2 cycles after the start edge; det=-14, det_completo=-14, overflow_flag=0.
REQ-029 3x3 [6,1,1;4,-2,5;2,8,7] -> done 9 cycles after the start edge; det_completo=-306, det=-50 (0xCE), overflow_flag=1.
REQ-030 2x2 [-128,127;127,-128] -> det_completo=255, det=-1, overflow_flag=1.
REQ-031 3x3 identity, then start asserted during the done cycle with the 2x2 case of REQ-028:
- first result: det=1
- second result: det=-14, with done exactly 2 cycles after the second start edge
REQ-032 reset pulsed at step 4 of a 3x3 computation -> next cycle all outputs 0, no done pulse; a following start yields a correct result.
REQ-033 start pulses and matriz changes during CALC -> ignored; the result and timing match the original request.
